apb_timer_slave: RTL and testbench
==================================

# apb_timer_slave

APB peripheral sitting directly downstream of the AHB-to-APB bridge: it decodes one bit of the bridge's `Pselx` and completes zero-wait-state APB reads and writes. It drives read data back onto `Prdata`, which the bridge returns on `Hrdata`. Internally it is a prescaled 32-bit down-counter timer with reload, sticky status and an optional interrupt.

## Interface
- `PSEL_IDX`, default 0: which bit of `Pselx` selects this slave (0..2).
- `Hclk` input 1: the single clock, shared with the bridge.
- `Hreset` input 1: reset, synchronous and active-high.
- `Pselx` input 3: bridge slave selects; only bit `PSEL_IDX` is used.
- `Penable` input 1: APB access-phase strobe.
- `Pwrite` input 1: 1 = write, 0 = read.
- `Paddr` input 32: only `[3:2]` is decoded; other bits are ignored.
- `Pwdata` input 32: write data.
- `Prdata` output 32: read data, registered.
- `irq` output 1: timer interrupt, level, registered.

## Operation
- Protocol FSM, states IDLE, SETUP, ACCESS; `sel = Pselx[PSEL_IDX]`.
  - IDLE→SETUP on `sel & !Penable`.
  - SETUP→ACCESS unconditionally; every access is zero-wait.
  - ACCESS→SETUP on `sel & !Penable` (back-to-back transfer), else IDLE.
- Protocol error: `sel & Penable` seen in IDLE sets sticky `STATUS.perr`. That access is ignored: no write, and `Prdata` is unchanged.
- Reads: in SETUP, `Prdata` is loaded at the clock edge with the addressed register, so it is valid throughout ACCESS. When not reading, `Prdata` holds its last value.
- Writes: committed at the edge ending ACCESS, i.e. the edge where `sel & Penable & Pwrite` is sampled in SETUP→ACCESS.
- Register map, by `Paddr[3:2]`:
  - 0 CTRL, RW: bit0 `en`, bit1 `reload`, bit2 `ie`, bits[15:8] `presc`; other bits read 0.
  - 1 LOAD, RW, 32 bits. A write also copies `Pwdata` into VALUE.
  - 2 VALUE, RO. Writes are ignored.
  - 3 STATUS: bit0 `expired`, bit1 `perr`, both write-1-to-clear; other bits read 0.
- Prescaler: 8-bit counter. While `en`=1 it counts 0..`presc`, then wraps to 0 and issues a one-cycle `tick`. While `en`=0 it is held at 0.
- On `tick`:
  - If VALUE≠0: VALUE decrements by 1.
  - If VALUE==0: set `expired`. Then, if `reload`=1, VALUE←LOAD; otherwise clear `en` (one-shot).
- Arithmetic is unsigned 32-bit. VALUE never wraps below 0.
- `irq` ← `expired & ie`, registered one cycle after either term changes.

## Timing
- Reset values: `Prdata`=0, `irq`=0, CTRL=0, LOAD=0, VALUE=0, STATUS=0, prescaler=0, FSM=IDLE.
- Reset asserted mid-transfer aborts the transfer. No register write occurs on that edge; the FSM restarts in IDLE.
- With `en` written to 1 at edge E, the first `tick` occurs at edge E+`presc`+1. Period = `presc`+1 cycles.
- From VALUE=N at enable to `expired` set: (N+1)·(`presc`+1) cycles.
- Read latency: the data is registered in SETUP. A read of VALUE returns its value at the SETUP edge.
- Simultaneous events:
  - LOAD write in the same cycle as `tick`: the write wins; VALUE=`Pwdata`, no decrement.
  - STATUS W1C in the same cycle that sets `expired`/`perr`: the set wins.
  - CTRL write of `en`=0 in the same cycle as `tick`: the `tick` is discarded.

## Configuration
- `APB_TIMER_IRQ_EN` defined:
  - CTRL bit2 `ie` is implemented.
  - `irq` behaves as specified above.
- Not defined:
  - CTRL bit2 reads 0 and writes to it are ignored.
  - `irq` is tied to 0.
  - `expired` still sets and clears as specified; it is polled via STATUS.

## Test plan
- Reset, then read all four registers → CTRL=0, LOAD=0, VALUE=0, STATUS=0; `irq`=0.
- Write LOAD=5 → read VALUE=5. Write CTRL=0x0000_0007 (`presc`=0, `en`, `reload`, `ie`):
  - `expired` and `irq` rise after 6 ticks.
  - VALUE reloads to 5.
  - Write STATUS=1 → `irq` drops the next cycle.
- One-shot: LOAD=2, CTRL=0x0000_0301 (`presc`=3, `en` only) → `expired` after 12 cycles; CTRL reads 0x0000_0300; VALUE stays 0.
- Back-to-back write then read at offsets 0x4 and 0x8, with SETUP following ACCESS directly → the write commits and the read returns the new VALUE.
- Drive `Penable`=1 with `sel` from IDLE → STATUS reads 0x2. Write STATUS=2 → reads 0x0.
- Assert `Hreset` during the ACCESS of a CTRL write of 0x1 → CTRL=0 after reset, FSM in IDLE, `irq`=0.

Source files
------------

// File: rtl/apb_timer_slave_if.sv
// APB bus bundle between the AHB-to-APB bridge (master)
// and the timer slave.
interface apb_timer_slave_if;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;

  modport master (
    output Pselx, Penable, Pwrite,
    output Paddr, Pwdata,
    input  Prdata
  );

  modport slave (
    input  Pselx, Penable, Pwrite,
    input  Paddr, Pwdata,
    output Prdata
  );
endinterface

// File: rtl/apb_timer_slave.sv
// Zero-wait APB slave around a prescaled 32-bit down-counter timer.
// Define APB_TIMER_IRQ_EN to implement CTRL.ie and the irq output.
module apb_timer_slave #(
  parameter int unsigned PSEL_IDX = 0
) (
  input  logic             Hclk,
  input  logic             Hreset,
  apb_timer_slave_if.slave bus,
  output logic             irq
);
  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e      state_q;
  logic        en_q, en_d;
  logic        rld_q, rld_d;
  logic        ie_q, ie_d;
  logic        exp_q, exp_d;
  logic        perr_q, perr_d;
  logic        irq_q;
  logic [7:0]  presc_q, presc_d;
  logic [7:0]  psc_q, psc_d;
  logic [31:0] load_q, load_d;
  logic [31:0] val_q, val_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rmux;

  logic sel, acc, wr, rd, perr_set;
  logic wr_ctrl, wr_load, wr_stat;
  logic tick, tick_ok, exp_set;
  logic unused;

  assign sel      = bus.Pselx[PSEL_IDX];
  assign acc      = (state_q == SETUP) & sel & bus.Penable;
  assign wr       = acc & bus.Pwrite;
  assign rd       = acc & ~bus.Pwrite;
  assign perr_set = (state_q == IDLE) & sel & bus.Penable;

  assign wr_ctrl = wr & (bus.Paddr[3:2] == 2'd0);
  assign wr_load = wr & (bus.Paddr[3:2] == 2'd1);
  assign wr_stat = wr & (bus.Paddr[3:2] == 2'd3);

  assign tick    = en_q & (psc_q == presc_q);
  // turning the timer off in the tick cycle swallows that tick
  assign tick_ok = tick & ~(wr_ctrl & ~bus.Pwdata[0]);
  assign exp_set = tick_ok & (val_q == 32'd0);

  always_comb begin
    rmux = 32'd0;
    unique case (bus.Paddr[3:2])
      2'd0: rmux = {16'd0, presc_q, 5'd0, ie_q, rld_q, en_q};
      2'd1: rmux = load_q;
      2'd2: rmux = val_q;
      2'd3: rmux = {30'd0, perr_q, exp_q};
    endcase
  end

  always_comb begin
    en_d    = en_q;
    rld_d   = rld_q;
    ie_d    = ie_q;
    presc_d = presc_q;
    load_d  = load_q;
    val_d   = val_q;
    psc_d   = (en_q & ~tick) ? psc_q + 8'd1 : 8'd0;
    if (tick_ok) begin
      if (val_q != 32'd0) val_d = val_q - 32'd1;
      else if (rld_q)     val_d = load_q;
      else                en_d  = 1'b0;
    end
    if (wr_ctrl) begin
      en_d    = bus.Pwdata[0];
      rld_d   = bus.Pwdata[1];
      presc_d = bus.Pwdata[15:8];
      psc_d   = 8'd0;
`ifdef APB_TIMER_IRQ_EN
      ie_d    = bus.Pwdata[2];
`endif
    end
    if (wr_load) begin
      load_d = bus.Pwdata;
      val_d  = bus.Pwdata;
    end
    // clear first, so a coincident hardware set wins
    exp_d   = exp_set | (exp_q & ~(wr_stat & bus.Pwdata[0]));
    perr_d  = perr_set | (perr_q & ~(wr_stat & bus.Pwdata[1]));
    rdata_d = rd ? rmux : rdata_q;
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      rld_q   <= 1'b0;
      ie_q    <= 1'b0;
      exp_q   <= 1'b0;
      perr_q  <= 1'b0;
      irq_q   <= 1'b0;
      presc_q <= 8'd0;
      psc_q   <= 8'd0;
      load_q  <= 32'd0;
      val_q   <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      unique case (state_q)
        IDLE:    state_q <= (sel & ~bus.Penable) ? SETUP : IDLE;
        SETUP:   state_q <= ACCESS;
        ACCESS:  state_q <= (sel & ~bus.Penable) ? SETUP : IDLE;
        default: state_q <= IDLE;
      endcase
      en_q    <= en_d;
      rld_q   <= rld_d;
      ie_q    <= ie_d;
      exp_q   <= exp_d;
      perr_q  <= perr_d;
      irq_q   <= exp_q & ie_q;
      presc_q <= presc_d;
      psc_q   <= psc_d;
      load_q  <= load_d;
      val_q   <= val_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.Prdata = rdata_q;
  assign irq        = irq_q;
  assign unused     = ^{bus.Pselx, bus.Paddr, bus.Pwdata};
endmodule

// File: tb/tb_apb_timer_slave.sv
// Bench for apb_timer_slave: directed checks plus random
// APB traffic against a transaction-level timer model.
module tb_apb_timer_slave;
  localparam int PIDX = 1;
`ifdef APB_TIMER_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic Hclk = 1'b0;
  logic Hreset = 1'b1;
  logic irq;

  apb_timer_slave_if bus();

  apb_timer_slave #(.PSEL_IDX(PIDX)) dut (
    .Hclk  (Hclk),
    .Hreset(Hreset),
    .bus   (bus),
    .irq   (irq)
  );

  always #5 Hclk = ~Hclk;

  int n_chk = 0;
  int n_err = 0;

  bit        m_en, m_rld, m_ie, m_exp, m_perr, m_irq;
  bit [7:0]  m_presc, m_psc;
  bit [31:0] m_load, m_val, m_prdata;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] reg_rd(input bit [1:0] a);
    case (a)
      2'd0:    return {16'd0, m_presc, 5'd0, m_ie, m_rld, m_en};
      2'd1:    return m_load;
      2'd2:    return m_val;
      default: return {30'd0, m_perr, m_exp};
    endcase
  endfunction

  task automatic model_reset();
    {m_en, m_rld, m_ie, m_exp, m_perr, m_irq} = '0;
    m_presc = 0; m_psc = 0;
    m_load = 0; m_val = 0; m_prdata = 0;
  endtask

  // one clock edge of the timer, given the bus event on it
  task automatic model_step(input bit wc, input bit [1:0] wa,
                            input bit [31:0] wd, input bit rc,
                            input bit [1:0] ra, input bit pe);
    bit kill, tk, nen, nexp, nperr, nirq;
    bit [7:0] npsc;
    bit [31:0] nval;
    kill  = wc && wa == 2'd0 && !wd[0];
    tk    = m_en && m_psc == m_presc && !kill;
    npsc  = (m_en && m_psc != m_presc) ? m_psc + 8'd1 : 8'd0;
    nen   = m_en; nval = m_val; nexp = m_exp; nperr = m_perr;
    nirq  = m_exp && m_ie;
    if (rc) m_prdata = reg_rd(ra);
    if (wc && wa == 2'd3) begin
      if (wd[0]) nexp = 1'b0;
      if (wd[1]) nperr = 1'b0;
    end
    if (pe) nperr = 1'b1;
    if (tk) begin
      if (m_val != 0) nval = m_val - 1;
      else begin
        nexp = 1'b1;
        if (m_rld) nval = m_load;
        else nen = 1'b0;
      end
    end
    if (wc && wa == 2'd0) begin
      nen = wd[0]; m_rld = wd[1]; m_ie = IRQ_EN && wd[2];
      m_presc = wd[15:8]; npsc = 0;
    end
    if (wc && wa == 2'd1) begin
      m_load = wd; nval = wd;
    end
    m_en = nen; m_val = nval; m_exp = nexp;
    m_perr = nperr; m_psc = npsc; m_irq = nirq;
  endtask

  task automatic edge_step(input bit wc, input bit [1:0] wa,
                           input bit [31:0] wd, input bit rc,
                           input bit [1:0] ra, input bit pe);
    @(posedge Hclk);
    model_step(wc, wa, wd, rc, ra, pe);
    #1;
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
    chk("prdata", bus.Prdata, m_prdata);
  endtask

  function automatic logic [2:0] sel_vec();
    logic [2:0] v;
    v = 3'($urandom);
    v[PIDX] = 1'b1;
    return v;
  endfunction

  task automatic bus_idle();
    bus.Pselx   = 3'($urandom) & ~(3'b001 << PIDX);
    bus.Penable = 1'($urandom);
    bus.Pwrite  = 1'($urandom);
    bus.Paddr   = $urandom;
    bus.Pwdata  = $urandom;
  endtask

  task automatic idle_n(input int n);
    bus_idle();
    for (int i = 0; i < n; i++) edge_step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic apb_write(input bit [1:0] a, input logic [31:0] d);
    bus.Pselx   = sel_vec();
    bus.Penable = 1'b0;
    bus.Pwrite  = 1'b1;
    bus.Paddr   = {28'($urandom), a, 2'($urandom)};
    bus.Pwdata  = d;
    edge_step(0, 0, 0, 0, 0, 0);
    bus.Penable = 1'b1;
    edge_step(1, a, d, 0, 0, 0);
    bus_idle();
  endtask

  task automatic apb_read(input bit [1:0] a, output logic [31:0] d);
    bus.Pselx   = sel_vec();
    bus.Penable = 1'b0;
    bus.Pwrite  = 1'b0;
    bus.Paddr   = {28'($urandom), a, 2'($urandom)};
    bus.Pwdata  = $urandom;
    edge_step(0, 0, 0, 0, 0, 0);
    bus.Penable = 1'b1;
    edge_step(0, 0, 0, 1, a, 0);
    d = bus.Prdata;
    bus_idle();
  endtask

  task automatic perr_ev(input bit pre_idle);
    if (pre_idle) idle_n(1);
    bus.Pselx   = sel_vec();
    bus.Penable = 1'b1;
    bus.Pwrite  = 1'($urandom);
    bus.Paddr   = $urandom;
    bus.Pwdata  = $urandom;
    edge_step(0, 0, 0, 0, 0, 1);
    bus_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int op;
    bit [1:0] a;
    logic [31:0] d;

    bus_idle();
    Hreset = 1'b1;
    repeat (2) @(posedge Hclk);
    model_reset();
    #1;
    Hreset = 1'b0;
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_prdata", bus.Prdata, 32'd0);
    apb_read(0, r); chk("rst_ctrl", r, 32'd0);
    apb_read(1, r); chk("rst_load", r, 32'd0);
    apb_read(2, r); chk("rst_value", r, 32'd0);
    apb_read(3, r); chk("rst_status", r, 32'd0);

    // reload mode, presc 0
    apb_write(1, 32'd5);
    apb_read(2, r); chk("load_to_value", r, 32'd5);
    apb_write(0, 32'h7);
    idle_n(5);
    apb_read(2, r); chk("reload_value", r, 32'd5);
    apb_read(3, r); chk("expired_set", r, 32'd1);
    chk("irq_rise", {31'd0, irq}, {31'd0, IRQ_EN});
    apb_write(3, 32'd1);
    chk("irq_hold", {31'd0, irq}, {31'd0, IRQ_EN});
    idle_n(1);
    chk("irq_drop", {31'd0, irq}, 32'd0);

    // one-shot, presc 3
    apb_write(0, 32'd0);
    apb_write(3, 32'd3);
    apb_write(1, 32'd2);
    apb_write(0, 32'h301);
    idle_n(10);
    apb_read(3, r); chk("oneshot_early", r, 32'd0);
    apb_read(3, r); chk("oneshot_exp", r, 32'd1);
    apb_read(0, r); chk("oneshot_ctrl", r, 32'h300);
    apb_read(2, r); chk("oneshot_value", r, 32'd0);
    chk("oneshot_irq", {31'd0, irq}, 32'd0);

    // back-to-back write then read
    apb_write(1, 32'h1234_5678);
    apb_read(2, r); chk("b2b_value", r, 32'h1234_5678);

    // protocol error
    apb_write(3, 32'd1);
    perr_ev(1'b1);
    apb_read(3, r); chk("perr_set", r, 32'd2);
    apb_write(3, 32'd2);
    apb_read(3, r); chk("perr_clr", r, 32'd0);

    // reset during ACCESS of a CTRL write
    apb_write(1, 32'd0);
    apb_write(0, 32'h5);
    idle_n(3);
    chk("pre_rst_irq", {31'd0, irq}, {31'd0, IRQ_EN});
    bus.Pselx   = sel_vec();
    bus.Penable = 1'b0;
    bus.Pwrite  = 1'b1;
    bus.Paddr   = 32'h0;
    bus.Pwdata  = 32'h1;
    edge_step(0, 0, 0, 0, 0, 0);
    bus.Penable = 1'b1;
    Hreset = 1'b1;
    @(posedge Hclk);
    model_reset();
    #1;
    Hreset = 1'b0;
    chk("rst2_irq", {31'd0, irq}, 32'd0);
    chk("rst2_prdata", bus.Prdata, 32'd0);
    perr_ev(1'b0);
    apb_read(3, r); chk("rst2_idle", r, 32'd2);
    apb_read(0, r); chk("rst2_ctrl", r, 32'd0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9);
      a  = 2'($urandom);
      d  = $urandom;
      if (op <= 3) begin
        if (a == 2'd0) d[15:8] = 8'($urandom_range(0, 3));
        if (a == 2'd1) d = $urandom_range(0, 12);
        apb_write(a, d);
      end else if (op <= 6) begin
        apb_read(a, r);
        chk("rand_rd", r, reg_rd(a) === reg_rd(a) ? m_prdata : 32'd0);
      end else if (op <= 8) begin
        idle_n($urandom_range(1, 8));
      end else begin
        perr_ev(1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
